rv32m_div_sequencer: RTL and testbench

Front-end sequencer for the RV32M divide path. It accepts DIV/DIVU/REM/REMU requests from the execute stage and resolves divide-by-zero and signed-overflow cases locally. All other requests are launched on the iterative shift-test-restore divider, and the selected quotient or remainder is returned over a valid/ready response port. It sits directly upstream of the divider: it owns operand holding, the `start` pulse, `finished` tracking and result selection.

---
 rtl/rv32m_pkg.sv | 39 +++
 rtl/rv32m_div_sequencer_if.sv | 34 +++
 rtl/shift_test_restore_divider.sv | 89 ++++++++
 rtl/rv32m_div_sequencer.sv | 150 +++++++++++++++
 tb/tb_rv32m_div_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_pkg.sv
// ---------------------------------------------------------------------------
// rv32m_pkg
// Shared types for the RV32M divide path:
//   div_op_t          - request opcode (DIV, DIVU, REM, REMU); signed when op[0]==0
//   div_seq_state_t   - sequencer FSM states
//   div_core_state_t  - iterative divider FSM states
//   DIV_INT_MIN(w)    - most negative two's-complement value for width w
//                       (truncate the result to w bits at the call site)
// ---------------------------------------------------------------------------
package rv32m_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } div_seq_state_t;

    typedef enum logic [1:0] {
        DC_IDLE,
        DC_SHIFT,
        DC_RESTORE,
        DC_ADJUST
    } div_core_state_t;

    localparam int unsigned DIV_MAX_W = 64;

    function automatic logic [DIV_MAX_W-1:0] DIV_INT_MIN(input int unsigned width);
        return {{(DIV_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/rv32m_div_sequencer_if.sv
// ---------------------------------------------------------------------------
// rv32m_div_sequencer_if
// Request/response bundle between the execute stage and the divide sequencer.
//   flush                 - kill the in-flight op (no response)
//   req_valid/req_ready   - request handshake carrying op, operand_a, operand_b
//   resp_valid/resp_ready - response handshake carrying result
// Modports: master = execute stage, slave = sequencer.
// ---------------------------------------------------------------------------
interface rv32m_div_sequencer_if #(
    parameter int N = 32
);
    import rv32m_pkg::*;

    logic          flush;
    logic          req_valid;
    logic          req_ready;
    div_op_t       op;
    logic [N-1:0]  operand_a;
    logic [N-1:0]  operand_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [N-1:0]  result;

    modport master (
        output flush, req_valid, op, operand_a, operand_b, resp_ready,
        input  req_ready, resp_valid, result
    );

    modport slave (
        input  flush, req_valid, op, operand_a, operand_b, resp_ready,
        output req_ready, resp_valid, result
    );

endinterface

// File: rtl/shift_test_restore_divider.sv
// ---------------------------------------------------------------------------
// shift_test_restore_divider
// Iterative restoring divider. Each of the N iterations takes two cycles
// (shift+subtract, then test+restore), followed by one sign-adjust cycle.
// Ports:
//   CLK, nRST (sync, active-low)
//   start                 - one-cycle pulse; restarts the divider at any time
//   is_signed, dividend, divisor
//                         - must stay stable for the whole operation because
//                           the magnitude conversion is combinational
//   finished              - high from the cycle after sign adjust until the
//                           next start
//   quotient, remainder   - valid while finished is high
// ---------------------------------------------------------------------------
module shift_test_restore_divider
    import rv32m_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start,
    input  logic          is_signed,
    input  logic [N-1:0]  dividend,
    input  logic [N-1:0]  divisor,
    output logic          finished,
    output logic [N-1:0]  quotient,
    output logic [N-1:0]  remainder
);
    localparam int CW = $clog2(N) + 1;

    div_core_state_t  state;
    logic [CW-1:0]    count;
    logic [N:0]       prem;     // partial remainder; bit N is the sign after subtract
    logic [N-1:0]     quo;      // dividend bits shift out as quotient bits shift in
    logic [N-1:0]     dividend_mag;
    logic [N-1:0]     divisor_mag;
    logic             neg_q;
    logic             neg_r;

    assign dividend_mag = (is_signed && dividend[N-1]) ? -dividend : dividend;
    assign divisor_mag  = (is_signed && divisor[N-1])  ? -divisor  : divisor;
    assign neg_q        = is_signed && (dividend[N-1] ^ divisor[N-1]);
    assign neg_r        = is_signed && dividend[N-1];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= DC_IDLE;
            count    <= '0;
            prem     <= '0;
            quo      <= '0;
            finished <= 1'b0;
        end else if (start) begin
            state    <= DC_SHIFT;
            count    <= '0;
            prem     <= '0;
            quo      <= dividend_mag;
            finished <= 1'b0;
        end else begin
            case (state)
                DC_SHIFT: begin
                    prem  <= {prem[N-1:0], quo[N-1]} - {1'b0, divisor_mag};
                    quo   <= {quo[N-2:0], 1'b0};
                    state <= DC_RESTORE;
                end
                DC_RESTORE: begin
                    if (prem[N]) begin
                        prem <= prem + {1'b0, divisor_mag};
                    end else begin
                        quo[0] <= 1'b1;
                    end
                    count <= count + 1'b1;
                    state <= (count == CW'(N - 1)) ? DC_ADJUST : DC_SHIFT;
                end
                DC_ADJUST: begin
                    quo      <= neg_q ? -quo : quo;
                    prem     <= {1'b0, (neg_r ? -prem[N-1:0] : prem[N-1:0])};
                    finished <= 1'b1;
                    state    <= DC_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quo;
    assign remainder = prem[N-1:0];

endmodule

// File: rtl/rv32m_div_sequencer.sv
// ---------------------------------------------------------------------------
// rv32m_div_sequencer
// Front-end for the RV32M divide path. Accepts DIV/DIVU/REM/REMU requests,
// answers divide-by-zero and signed overflow directly, otherwise launches the
// iterative divider and returns the selected quotient or remainder.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - rv32m_div_sequencer_if.slave (flush, request and response handshakes)
// Optional feature macro: RV32M_DIV_RESULT_CACHE_EN
//   When defined, a one-entry cache of the last completed divider op lets a
//   matching request (same a, b, signedness) respond in one cycle, which
//   covers the DIV followed by REM idiom.
// ---------------------------------------------------------------------------
module rv32m_div_sequencer
    import rv32m_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    rv32m_div_sequencer_if.slave  bus
);
    localparam logic [N-1:0] INT_MIN = N'(DIV_INT_MIN(N));

    div_seq_state_t  state;
    div_op_t         op_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            signed_q;
    logic [N-1:0]    result_q;

    logic            div_start;
    logic            div_finished;
    logic [N-1:0]    div_quotient;
    logic [N-1:0]    div_remainder;

    logic            req_signed;
    logic            req_is_rem;
    logic            req_div_zero;
    logic            req_overflow;
    logic            req_cache_hit;
    logic [N-1:0]    cache_field;

    assign req_signed   = ~bus.op[0];
    assign req_is_rem   = bus.op[1];
    assign req_div_zero = (bus.operand_b == '0);
    assign req_overflow = req_signed && (bus.operand_a == INT_MIN) && (bus.operand_b == '1);

`ifdef RV32M_DIV_RESULT_CACHE_EN
    logic            cache_valid;
    logic            cache_signed;
    logic [N-1:0]    cache_a;
    logic [N-1:0]    cache_b;
    logic [N-1:0]    cache_q;
    logic [N-1:0]    cache_r;

    assign req_cache_hit = cache_valid && (cache_a == bus.operand_a) &&
                           (cache_b == bus.operand_b) && (cache_signed == req_signed);
    assign cache_field   = req_is_rem ? cache_r : cache_q;

    // Filled only when a divider op completes without a flush in that cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cache_valid <= 1'b0;
        end else if (!bus.flush && state == WAIT && div_finished) begin
            cache_valid  <= 1'b1;
            cache_a      <= a_q;
            cache_b      <= b_q;
            cache_signed <= signed_q;
            cache_q      <= div_quotient;
            cache_r      <= div_remainder;
        end
    end
`else
    assign req_cache_hit = 1'b0;
    assign cache_field   = '0;
`endif

    // Flush wins over everything, including a request or resp_ready in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            op_q     <= OP_DIV;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q     <= bus.op;
                        a_q      <= bus.operand_a;
                        b_q      <= bus.operand_b;
                        signed_q <= req_signed;
                        if (req_div_zero) begin
                            result_q <= req_is_rem ? bus.operand_a : '1;
                            state    <= RESP;
                        end else if (req_overflow) begin
                            result_q <= req_is_rem ? '0 : bus.operand_a;
                            state    <= RESP;
                        end else if (req_cache_hit) begin
                            result_q <= cache_field;
                            state    <= RESP;
                        end else begin
                            state <= START;
                        end
                    end
                end
                // finished is not looked at here: it may still be high from the last op.
                START: state <= WAIT;
                WAIT: begin
                    if (div_finished) begin
                        result_q <= (op_q == OP_REM || op_q == OP_REMU) ? div_remainder
                                                                        : div_quotient;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_start = (state == START);

    shift_test_restore_divider #(.N(N)) u_divider (
        .CLK       (CLK),
        .nRST      (~RST),
        .start     (div_start),
        .is_signed (signed_q),
        .dividend  (a_q),
        .divisor   (b_q),
        .finished  (div_finished),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign bus.req_ready  = (state == IDLE) && !bus.flush;
    assign bus.resp_valid = (state == RESP);
    assign bus.result     = result_q;

endmodule

// File: tb/tb_rv32m_div_sequencer.sv
module tb_rv32m_div_sequencer;
    import rv32m_pkg::*;

    localparam int N        = 32;
    localparam int DIV_LAT  = 2 * N + 4;
    localparam int MAX_WAIT = 200;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference cache: operands of the last op that went through the divider.
    bit          mc_valid = 1'b0;
    logic [31:0] mc_a;
    logic [31:0] mc_b;
    bit          mc_signed;

    rv32m_div_sequencer_if #(.N(N)) bus ();

    rv32m_div_sequencer #(.N(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit op_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic bit op_rem(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic bit is_special(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (op_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics computed with plain arithmetic.
    function automatic logic [31:0] model_result(input div_op_t op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sres;
        sa = a;
        sb = b;
        if (b == 32'd0) return op_rem(op) ? a : 32'hFFFF_FFFF;
        if (op_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op_rem(op) ? 32'd0 : a;
        if (op_signed(op)) begin
            if (op_rem(op)) sres = sa % sb;
            else            sres = sa / sb;
            return sres;
        end
        return op_rem(op) ? (a % b) : (a / b);
    endfunction

    // mode 0: consume with resp_ready; 1: flush alone in RESP; 2: flush with resp_ready.
    task automatic run_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string tag,
                          input int hold, input int mode);
        int cyc;
        int exp_lat;
        bit sgn;
        sgn = op_signed(op);
        if (is_special(op, a, b)) begin
            exp_lat = 1;
        end else begin
            exp_lat = DIV_LAT;
`ifdef RV32M_DIV_RESULT_CACHE_EN
            if (mc_valid && mc_a == a && mc_b == b && mc_signed == sgn) exp_lat = 1;
`endif
            if (exp_lat != 1) begin
                mc_valid  = 1'b1;
                mc_a      = a;
                mc_b      = b;
                mc_signed = sgn;
            end
        end

        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.req_valid = 1'b1;
        #1;
        check({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        cyc = 1;
        while (bus.resp_valid !== 1'b1 && cyc < MAX_WAIT) begin
            @(negedge CLK);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, bus.result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check($sformatf("%s hold%0d result", tag, i), bus.result, exp_res);
            check($sformatf("%s hold%0d resp_valid", tag, i), {31'd0, bus.resp_valid}, 32'd1);
        end
        bus.resp_ready = (mode != 1);
        bus.flush      = (mode != 0);
        @(negedge CLK);
        bus.resp_ready = 1'b0;
        bus.flush      = 1'b0;
        #1;
        check({tag, " post resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, " post req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int          cyc;
        bit          seen;
        div_op_t     rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.op         = OP_DIV;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        bus.resp_ready = 1'b0;

        // Reset
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Directed divider and special cases
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7", 0, 0);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, "remu_100_7", 0, 0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", 0, 0);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", 0, 0);
        run_op(OP_DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, "div_by_zero", 0, 0);
        run_op(OP_REMU, 32'h1234, 32'd0, 32'h1234, "remu_by_zero", 0, 0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow", 0, 0);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow", 0, 0);

        // flush together with req_valid: nothing accepted
        bus.op        = OP_DIV;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd0;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        #1;
        check("flush+req req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check("flush+req resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("flush+req req_ready after", {31'd0, bus.req_ready}, 32'd1);

        // flush of an in-flight divider op at cycle 30
        @(negedge CLK);
        bus.op        = OP_DIVU;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        bus.req_valid = 1'b1;
        #1;
        check("flush_op req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc < 30) begin
            if (bus.resp_valid) seen = 1'b1;
            @(negedge CLK);
            cyc++;
        end
        bus.flush = 1'b1;
        @(negedge CLK);
        bus.flush = 1'b0;
        #1;
        check("flush_op req_ready c31", {31'd0, bus.req_ready}, 32'd1);
        check("flush_op resp_valid c31", {31'd0, bus.resp_valid}, 32'd0);
        repeat (80) begin
            @(negedge CLK);
            if (bus.resp_valid) seen = 1'b1;
        end
        check("flush_op no response", {31'd0, seen}, 32'd0);

        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, "divu_9_3_hold", 5, 0);
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "div_100_m7", 0, 0);
        run_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, "rem_100_m7", 0, 0);

        // flush while in RESP, alone and together with resp_ready
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, "resp_flush", 0, 1);
        run_op(OP_REM, 32'd5, 32'd0, 32'd5, "resp_flush_ready", 0, 2);

        // Randomized ops against the reference model
        for (int i = 0; i < 12; i++) begin
            rop = div_op_t'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 5000); rb = $urandom_range(1, 50); end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            run_op(rop, ra, rb, model_result(rop, ra, rb), $sformatf("rand%0d", i), 0, 0);
            if ($urandom_range(0, 1) == 1) begin
                rop = div_op_t'({~rop[1], rop[0]});
                run_op(rop, ra, rb, model_result(rop, ra, rb), $sformatf("rand%0d_pair", i), 0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
